// File: rtl/plru_pkg.sv
// Shared helpers for the tree pseudo-LRU unit: heap-ordered node bit updates,
// subtree way masks and node counting, sized for up to 64 ways per set.
package plru_pkg;

    localparam int MAX_WAYS   = 64;
    localparam int MAX_LEVELS = 6;

    typedef logic [MAX_WAYS-2:0] node_vec_t;
    typedef logic [MAX_WAYS-1:0] way_vec_t;

    function automatic int plru_node_count(input int assoc);
        return assoc - 1;
    endfunction

    function automatic int plru_levels(input int assoc);
        int n;
        n = 0;
        for (int l = 1; l <= MAX_LEVELS; l++) begin
            if ((1 << l) <= assoc) n = l;
        end
        return n;
    endfunction

    // Every node on the path to 'way' is pointed at the sibling subtree.
    function automatic node_vec_t plru_update(input node_vec_t state,
                                              input int way,
                                              input int assoc);
        node_vec_t next;
        node_vec_t one;
        int        node;
        int        levels;
        int        bit_r;
        next   = state;
        one    = node_vec_t'(1);
        node   = 0;
        levels = plru_levels(assoc);
        for (int l = 0; l < MAX_LEVELS; l++) begin
            if (l < levels) begin
                bit_r = (way >> (levels - 1 - l)) & 1;
                next  = (next & ~(one << node)) | (node_vec_t'(bit_r == 0) << node);
                node  = 2 * node + 1 + bit_r;
            end
        end
        return next;
    endfunction

    // Nodes at or beyond assoc-1 are leaves, so a leaf index yields a one-hot mask.
    function automatic way_vec_t plru_subtree_mask(input int node, input int assoc);
        way_vec_t mask;
        way_vec_t one;
        int       depth;
        int       span;
        int       pos;
        mask  = '0;
        one   = way_vec_t'(1);
        depth = 0;
        for (int d = 1; d <= MAX_LEVELS; d++) begin
            if (node + 1 >= (1 << d)) depth = d;
        end
        span = assoc >> depth;
        pos  = node + 1 - (1 << depth);
        for (int w = 0; w < MAX_WAYS; w++) begin
            if (w >= pos * span && w < (pos + 1) * span) mask = mask | (one << w);
        end
        return mask;
    endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// Combinational victim picker: lowest invalid unlocked way first, otherwise a
// lock-aware walk of the PLRU tree; flags the all-locked case.
module plru_victim_sel
    import plru_pkg::*;
#(
    parameter int ASSOCIATIVITY = 8,
    parameter int WAY_BITS      = $clog2(ASSOCIATIVITY),
    parameter int NODES         = ASSOCIATIVITY - 1
) (
    input  logic [NODES-1:0]         node_bits,
    input  logic [ASSOCIATIVITY-1:0] way_valid,
    input  logic [ASSOCIATIVITY-1:0] way_lock,
    output logic [WAY_BITS-1:0]      way,
    output logic                     none
);

    logic [ASSOCIATIVITY-1:0] usable;
    logic [ASSOCIATIVITY-1:0] free_ways;
    logic [ASSOCIATIVITY-1:0] left_mask;
    logic [ASSOCIATIVITY-1:0] right_mask;
    logic [WAY_BITS-1:0]      free_way;
    logic [WAY_BITS-1:0]      walk_way;
    logic                     go_right;
    int                       node;

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        usable     = ~way_lock;
        free_ways  = ~way_valid & usable;
        free_way   = '0;
        walk_way   = '0;
        go_right   = 1'b0;
        left_mask  = '0;
        right_mask = '0;
        node       = 0;
        way        = '0;
        none       = (usable == '0);

        // Scanning downwards leaves the lowest free way as the final winner.
        for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
            if (((free_ways >> i) & ASSOCIATIVITY'(1)) != '0) free_way = WAY_BITS'(i);
        end

        for (int l = 0; l < WAY_BITS; l++) begin
            left_mask  = ASSOCIATIVITY'(plru_subtree_mask(2 * node + 1, ASSOCIATIVITY));
            right_mask = ASSOCIATIVITY'(plru_subtree_mask(2 * node + 2, ASSOCIATIVITY));
            go_right   = ((node_bits >> node) & NODES'(1)) != '0;
            if (go_right && (right_mask & usable) == '0) begin
                go_right = 1'b0;
            end else if (!go_right && (left_mask & usable) == '0) begin
                go_right = 1'b1;
            end
            walk_way = (walk_way << 1) | WAY_BITS'(go_right);
            node     = 2 * node + 1 + int'(go_right);
        end

        if (free_ways != '0) begin
            way = free_way;
        end else if (!none) begin
            way = walk_way;
        end
    end

endmodule

// File: rtl/plru_tree.sv
// Tree pseudo-LRU replacement unit: per-set node bits in flops, same-cycle
// update forwarding into the lookup, and a registered victim one cycle later.
module plru_tree
    import plru_pkg::*;
#(
    parameter int ASSOCIATIVITY = 8,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = $clog2(ENTRIES),
    parameter int WAY_BITS      = $clog2(ASSOCIATIVITY)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_valid,
    input  logic [INDEX_BITS-1:0]    lookup_index,
    input  logic [ASSOCIATIVITY-1:0] way_valid,
    input  logic [ASSOCIATIVITY-1:0] way_lock,
    input  logic                     update_valid,
    input  logic [INDEX_BITS-1:0]    update_index,
    input  logic [WAY_BITS-1:0]      update_way,
    output logic                     victim_valid,
    output logic [WAY_BITS-1:0]      victim_way,
    output logic                     victim_none
);

    localparam int NODES = plru_node_count(ASSOCIATIVITY);

    logic [NODES-1:0]    tree_q [ENTRIES];
    logic [NODES-1:0]    upd_state;
    logic [NODES-1:0]    sel_state;
    logic                fwd_hit;
    logic [WAY_BITS-1:0] sel_way;
    logic                sel_none;

    assign upd_state = NODES'(plru_update(node_vec_t'(tree_q[update_index]),
                                          int'(update_way), ASSOCIATIVITY));
    assign fwd_hit   = update_valid && (update_index == lookup_index);
    assign sel_state = fwd_hit ? upd_state : tree_q[lookup_index];

    plru_victim_sel #(
        .ASSOCIATIVITY (ASSOCIATIVITY),
        .WAY_BITS      (WAY_BITS),
        .NODES         (NODES)
    ) u_victim_sel (
        .node_bits (sel_state),
        .way_valid (way_valid),
        .way_lock  (way_lock),
        .way       (sel_way),
        .none      (sel_none)
    );

    // NOTE: the state array is reset on purpose -- the first lookup after reset must
    // see an all-zero tree, so this stays flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                tree_q[e[INDEX_BITS-1:0]] <= '0;
            end
        end else if (update_valid) begin
            tree_q[update_index] <= upd_state;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            victim_valid <= 1'b0;
            victim_way   <= '0;
            victim_none  <= 1'b0;
        end else begin
            victim_valid <= lookup_valid;
            if (lookup_valid) begin
                victim_way  <= sel_way;
                victim_none <= sel_none;
            end
        end
    end

endmodule

// File: tb/tb_plru_tree.sv
// Self-checking bench for plru_tree: directed cases plus random traffic checked
// against a recency-timestamp model of tree pseudo-LRU.
module tb_plru_tree;

    localparam int ASSOC      = 8;
    localparam int ENTRIES    = 256;
    localparam int INDEX_BITS = 8;
    localparam int WAY_BITS   = 3;

    logic                  clk;
    logic                  rst;
    logic                  lookup_valid;
    logic [INDEX_BITS-1:0] lookup_index;
    logic [ASSOC-1:0]      way_valid;
    logic [ASSOC-1:0]      way_lock;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_index;
    logic [WAY_BITS-1:0]   update_way;
    logic                  victim_valid;
    logic [WAY_BITS-1:0]   victim_way;
    logic                  victim_none;

    plru_tree #(
        .ASSOCIATIVITY (ASSOC),
        .ENTRIES       (ENTRIES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_index (lookup_index),
        .way_valid    (way_valid),
        .way_lock     (way_lock),
        .update_valid (update_valid),
        .update_index (update_index),
        .update_way   (update_way),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .victim_none  (victim_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Model: time of the last access per way; 0 means never accessed since reset.
    int stamp;
    int ts [ENTRIES][ASSOC];
    bit exp_valid;
    int exp_way;
    bit exp_none;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // A subtree's LRU side is the half not holding its most recent access.
    function automatic bit lru_right(input int set, input int lo, input int size);
        int best;
        int best_ts;
        best    = -1;
        best_ts = 0;
        for (int w = lo; w < lo + size; w++) begin
            if (ts[set][w] > best_ts) begin
                best_ts = ts[set][w];
                best    = w;
            end
        end
        if (best < 0) return 1'b0;
        return best < lo + size / 2;
    endfunction

    function automatic bit all_locked(input logic [ASSOC-1:0] wl, input int lo, input int size);
        for (int w = lo; w < lo + size; w++) begin
            if (!wl[w]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_victim(input int set, input logic [ASSOC-1:0] wv,
                                input logic [ASSOC-1:0] wl, output int way, output bit none);
        int lo;
        int size;
        int half;
        bit right;
        none = (wl == '1);
        way  = -1;
        for (int w = 0; w < ASSOC; w++) begin
            if (way < 0 && !wv[w] && !wl[w]) way = w;
        end
        if (way >= 0) return;
        way = 0;
        if (none) return;
        lo   = 0;
        size = ASSOC;
        while (size > 1) begin
            half  = size / 2;
            right = lru_right(set, lo, size);
            if (right && all_locked(wl, lo + half, half)) right = 1'b0;
            else if (!right && all_locked(wl, lo, half)) right = 1'b1;
            if (right) lo = lo + half;
            size = half;
        end
        way = lo;
    endtask

    task automatic step(input bit r, input bit lv, input int li, input logic [ASSOC-1:0] wv,
                        input logic [ASSOC-1:0] wl, input bit uv, input int ui, input int uw,
                        input string tag);
        rst          = r;
        lookup_valid = lv;
        lookup_index = INDEX_BITS'(li);
        way_valid    = wv;
        way_lock     = wl;
        update_valid = uv;
        update_index = INDEX_BITS'(ui);
        update_way   = WAY_BITS'(uw);
        @(posedge clk);
        if (r) begin
            for (int s = 0; s < ENTRIES; s++)
                for (int w = 0; w < ASSOC; w++) ts[s][w] = 0;
            stamp     = 0;
            exp_valid = 1'b0;
            exp_way   = 0;
            exp_none  = 1'b0;
        end else begin
            if (uv) begin
                stamp++;
                ts[ui][uw] = stamp;
            end
            exp_valid = lv;
            if (lv) model_victim(li, wv, wl, exp_way, exp_none);
        end
        #1;
        check({tag, ".valid"}, 32'(victim_valid), 32'(exp_valid));
        check({tag, ".way"},   32'(victim_way),   32'(exp_way));
        check({tag, ".none"},  32'(victim_none),  32'(exp_none));
    endtask

    task automatic lookup_expect(input int li, input logic [ASSOC-1:0] wv, input logic [ASSOC-1:0] wl,
                                 input int ew, input bit en, input string tag);
        step(1'b0, 1'b1, li, wv, wl, 1'b0, 0, 0, tag);
        check({tag, ".spec_way"},  32'(victim_way),  32'(ew));
        check({tag, ".spec_none"}, 32'(victim_none), 32'(en));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        stamp    = 0;
        rst = 1'b1; lookup_valid = 1'b0; lookup_index = '0; way_valid = '1; way_lock = '0;
        update_valid = 1'b0; update_index = '0; update_way = '0;

        step(1'b1, 1'b0, 0, 8'hFF, 8'h00, 1'b0, 0, 0, "reset");
        lookup_expect(5, 8'hFF, 8'h00, 0, 1'b0, "reset_default");

        step(1'b0, 1'b0, 0, 8'hFF, 8'h00, 1'b1, 5, 0, "upd_w0");
        lookup_expect(5, 8'hFF, 8'h00, 4, 1'b0, "tree_upd_a");
        step(1'b0, 1'b0, 0, 8'hFF, 8'h00, 1'b1, 5, 4, "upd_w4");
        lookup_expect(5, 8'hFF, 8'h00, 2, 1'b0, "tree_upd_b");

        lookup_expect(5, 8'b1111_0111, 8'h00,        3, 1'b0, "inv_prio");
        lookup_expect(5, 8'b1111_0011, 8'b0000_1000, 2, 1'b0, "inv_locked");

        step(1'b1, 1'b0, 0, 8'hFF, 8'h00, 1'b0, 0, 0, "reset2");
        lookup_expect(5, 8'hFF, 8'h0F, 4, 1'b0, "lock_redirect");
        lookup_expect(5, 8'hFF, 8'hFF, 0, 1'b1, "all_locked");
        step(1'b0, 1'b0, 0, 8'hFF, 8'h00, 1'b0, 0, 0, "hold");

        step(1'b1, 1'b0, 0, 8'hFF, 8'h00, 1'b0, 0, 0, "reset3");
        step(1'b0, 1'b1, 7, 8'hFF, 8'h00, 1'b1, 7, 0, "fwd_same");
        check("fwd_same.spec_way", 32'(victim_way), 32'd4);
        step(1'b1, 1'b0, 0, 8'hFF, 8'h00, 1'b0, 0, 0, "reset4");
        step(1'b0, 1'b1, 7, 8'hFF, 8'h00, 1'b1, 6, 0, "fwd_diff");
        check("fwd_diff.spec_way", 32'(victim_way), 32'd0);

        step(1'b0, 1'b0, 0, 8'hFF, 8'h00, 1'b1, 5, 0, "pre_rst_upd");
        step(1'b1, 1'b1, 5, 8'hFF, 8'h00, 1'b0, 0, 0, "rst_drop");
        check("rst_drop.spec_valid", 32'(victim_valid), 32'd0);
        lookup_expect(5, 8'hFF, 8'h00, 0, 1'b0, "after_rst");

        for (int i = 0; i < 800; i++) begin
            bit               r;
            bit               lv;
            bit               uv;
            logic [ASSOC-1:0] wv;
            logic [ASSOC-1:0] wl;
            int               sel;
            r   = ($urandom_range(0, 63) == 0);
            lv  = ($urandom_range(0, 9) < 7);
            uv  = ($urandom_range(0, 9) < 6);
            wv  = ($urandom_range(0, 3) == 0) ? ASSOC'($urandom) : '1;
            sel = $urandom_range(0, 9);
            if (sel == 0)     wl = '1;
            else if (sel < 4) wl = ASSOC'($urandom) & ASSOC'($urandom);
            else              wl = '0;
            step(r, lv, $urandom_range(0, 3), wv, wl, uv, $urandom_range(0, 3),
                 $urandom_range(0, ASSOC - 1), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/plru_tree.md
# plru_tree

Parametrised tree pseudo-LRU replacement unit for set-associative caches of any power-of-two associativity. Per-set tree state is held in flops. A lookup returns a registered victim way one cycle later, with three priorities: invalid ways first, locked ways never chosen, hits from the same cycle forwarded. The unit sits beside the tag arrays in the data and instruction cache controllers and replaces the fixed 4-way bank-split LRU.

## Interface
- ASSOCIATIVITY, 8, ways per set; power of two, at least 2.
- ENTRIES, 256, number of sets.
- INDEX_BITS, $clog2(ENTRIES), set index width.
- WAY_BITS, $clog2(ASSOCIATIVITY), way number width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  request a victim for lookup_index.
- lookup_index  in  INDEX_BITS  set to pick a victim in.
- way_valid  in  ASSOCIATIVITY  valid bits of the looked-up set, sampled with the lookup.
- way_lock  in  ASSOCIATIVITY  ways excluded from replacement, sampled with the lookup.
- update_valid  in  1  record an access (hit or fill).
- update_index  in  INDEX_BITS  set that was accessed.
- update_way  in  WAY_BITS  way that was accessed.
- victim_valid  out  1  victim_way and victim_none are meaningful this cycle.
- victim_way  out  WAY_BITS  chosen victim.
- victim_none  out  1  every way is locked; no replacement is possible.

## Operation
- **State.** Each set holds ASSOCIATIVITY-1 node bits in heap order.
  - Node 0 is the root; node n has children 2n+1 and 2n+2.
  - Leaf position k maps to way k.
  - Bit value 0 means the LRU side is left (lower ways); 1 means right.
- **Update.** Every node on the root-to-leaf path of update_way is set to point away from that way: 1 if the way lies in the left subtree, 0 if in the right. Off-path nodes are unchanged.
- **Victim selection** is evaluated in priority order:
  1. If any way has way_valid=0 and way_lock=0, the victim is the lowest-numbered such way.
  2. Otherwise, walk the tree from the root. At each node, follow the bit unless every way under the indicated child is locked; in that case take the other child.
  3. If every way is locked, assert victim_none=1 and set victim_way=0.
- **Forwarding.** When lookup_valid and update_valid are both high with equal indices in the same cycle, selection uses the post-update node bits.
- **Write-only hits.** An update is applied regardless of the way's lock or valid state.
- **Lookup is read-only.** A lookup does not modify state; the controller issues the fill's update separately.

## Timing
- **Reset.** All node bits clear to 0 in the reset cycle. Outputs read victim_valid=0, victim_way=0, victim_none=0 from the cycle after rst is sampled high.
- **Reset mid-operation.** A lookup accepted in the same cycle as rst is dropped; no victim_valid follows.
- **Lookup latency is 1 cycle.** A lookup accepted at edge t produces victim_valid=1 with the result during cycle t+1. Outputs are registered.
- **No backpressure.** One lookup and one update can be accepted every cycle.
- **Holding outputs.** When no lookup is accepted, victim_valid=0 and victim_way/victim_none hold their last values.
- **Update latency.** An update at edge t is visible to lookups at edge t+1, and to same-edge lookups through forwarding.
- **Back-to-back updates** to the same set are applied in order. No update is lost.
- **way_valid/way_lock** are sampled only on the lookup edge.

## Structure
- **Shared package plru_pkg:**
  - function plru_update(state, way) returning the new node bits.
  - function plru_subtree_mask(node) returning the way mask under a node.
  - A node-count constant expression.
- **Sub-module plru_victim_sel.** Purely combinational, parametrised by ASSOCIATIVITY. Inputs: node bits, way_valid, way_lock. Outputs: way and none. It contains the invalid-priority encoder and the lock-aware tree walk.
- **Top level** holds the state array, the forwarding mux, the update write port and the output registers.

## Test plan
- **Reset default.** ASSOCIATIVITY=8. After rst, lookup set 5 with way_valid=8'hFF, way_lock=0 → next cycle victim_valid=1, victim_way=0, victim_none=0.
- **Tree update.** Update set 5 way 0, then lookup → victim 4. Then update way 4 and lookup → victim 2.
- **Invalid priority.** way_valid=8'b1111_0111 with any tree state → victim 3. Add way_lock=8'b0000_1000 with way_valid=8'b1111_0011 → victim 2.
- **Lock redirect.** After reset, way_lock=8'h0F, all ways valid → victim 4. With way_lock=8'hFF → victim_none=1, victim_way=0.
- **Forwarding.** After reset, in the same cycle issue update set 7 way 0 and lookup set 7 → victim 4. Same stimulus on different sets (update set 6, lookup set 7) → victim 0.
- **Reset mid-stream.** Assert rst in the same cycle as a lookup → victim_valid stays 0. Then lookup set 5 → victim 0, with prior updates erased.
